hazard_fwd_ctrl: RTL

//   Hazard/forwarding controller for the 5-stage pipeline. It drives the flush, forward_op1/2
//   and rD1/rD2_forward inputs of the ID/EX pipeline register, and the stall/flush controls for
//   the PC and IF/ID. It resolves RAW hazards by forwarding from EX/MEM/WB, inserts load-use

---
 rtl/hazard_fwd_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: operand forwarding from
// EX/MEM/WB, load-use bubbles and wrong-path squashing after a taken redirect in EX.
module hazard_fwd_ctrl #(
  parameter logic [1:0]  WSEL_RAM     = 2'b01,
  parameter int unsigned LOAD_STALL   = 1,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_wR,
  input  logic        ex_rf_we,
  input  logic [1:0]  ex_rf_wsel,
  input  logic [31:0] ex_wd,
  input  logic [4:0]  mem_wR,
  input  logic        mem_rf_we,
  input  logic [31:0] mem_wd,
  input  logic [4:0]  wb_wR,
  input  logic        wb_rf_we,
  input  logic [31:0] wb_wd,
  input  logic        ex_redirect,
  output logic        stall,
  output logic        flush_if_id,
  output logic        flush,
  output logic        forward_op1,
  output logic        forward_op2,
  output logic [31:0] rD1_forward,
  output logic [31:0] rD2_forward
);

  typedef enum logic [1:0] {StIdle, StStall, StRedir} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic [1:0][4:0]  rs;
  logic [1:0]       use_rs;
  logic [1:0]       lu_op;
  logic [1:0]       fwd_op;
  logic [1:0][31:0] fwd_data;
  logic             lu;
  logic             stall_c, flush_c, flush_if_id_c;

  assign rs     = {id_rs2, id_rs1};
  assign use_rs = {id_use_rs2, id_use_rs1};

  // A load match in EX blocks older stages: their value would be stale.
  always_comb begin
    lu_op    = '0;
    fwd_op   = '0;
    fwd_data = '0;
    for (int k = 0; k < 2; k++) begin
      if (use_rs[k] && (rs[k] != 5'd0)) begin
        if (ex_rf_we && (ex_wR == rs[k])) begin
          if (ex_rf_wsel == WSEL_RAM) begin
            lu_op[k] = 1'b1;
          end else begin
            fwd_op[k]   = 1'b1;
            fwd_data[k] = ex_wd;
          end
        end else if (mem_rf_we && (mem_wR == rs[k])) begin
          fwd_op[k]   = 1'b1;
          fwd_data[k] = mem_wd;
        end else if (wb_rf_we && (wb_wR == rs[k])) begin
          fwd_op[k]   = 1'b1;
          fwd_data[k] = wb_wd;
        end
      end
    end
  end

  assign lu = |lu_op;

  // cnt holds the number of further cycles to spend in STALL/REDIR after the current one.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_c       = 1'b0;
    flush_c       = 1'b0;
    flush_if_id_c = 1'b0;
    case (state_q)
      StRedir: begin
        flush_if_id_c = 1'b1;
        flush_c       = 1'b1;
        cnt_d         = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          state_d = StIdle;
          cnt_d   = 2'd0;
        end
      end
      StIdle, StStall: begin
        if (ex_redirect) begin
          flush_if_id_c = 1'b1;
          flush_c       = 1'b1;
          state_d       = StIdle;
          cnt_d         = 2'd0;
          if (FLUSH_CYCLES > 1) begin
            state_d = StRedir;
            cnt_d   = 2'(FLUSH_CYCLES - 1);
          end
        end else if (state_q == StStall) begin
          stall_c = 1'b1;
          flush_c = 1'b1;
          cnt_d   = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            state_d = StIdle;
            cnt_d   = 2'd0;
          end
        end else if (lu) begin
          stall_c = 1'b1;
          flush_c = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = StStall;
            cnt_d   = 2'(LOAD_STALL - 1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are combinational, so gate them to keep everything quiet during reset.
  assign stall       = rst_n & stall_c;
  assign flush       = rst_n & flush_c;
  assign flush_if_id = rst_n & flush_if_id_c;
  assign forward_op1 = rst_n & fwd_op[0];
  assign forward_op2 = rst_n & fwd_op[1];
  assign rD1_forward = rst_n ? fwd_data[0] : 32'd0;
  assign rD2_forward = rst_n ? fwd_data[1] : 32'd0;

endmodule
